v810_bus_target: RTL and testbench

Memory-mapped responder for the V810 external bus: the target-side end of the A/D/BEn/MRQn/RW/BCYSTn/READYn/SZRQn protocol driven by the CPU. Decodes bus cycles addressed to its window, inserts a programmable number of wait states, and services reads and writes from a synchronous single-port word memory (on-chip RAM/ROM model). Sits on the shared system bus next to the `v810` core; several instances with disjoint windows share READYn and the data bus through output enables.

---
 rtl/v810_bus_target.sv | 185 ++++++++++++++++++
 tb/tb_v810_bus_target.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v810_bus_target.sv
// v810_bus_target: target-side responder for the V810 external bus.
// Decodes CPU bus cycles addressed to a 2^(ADDR_W+2)-byte window at BASE,
// inserts WAIT_STATES wait cycles per access and services reads and writes
// from a synchronous single-port word memory (read data one CE cycle late).
// Several instances with disjoint windows may share READYn and the data bus;
// DOE tells the board when this instance drives D_O.
//
// Build option: define V810_BUS_TARGET_SZRQ_EN to make the target a 16-bit
// port. Accesses that span both halfwords are then narrowed to the lower
// half and SZRQn is pulled low with READYn so the CPU re-issues the upper
// half. Without the macro the port is 32 bits wide and SZRQn stays high.

module v810_bus_target #(
  parameter logic [31:0] BASE        = 32'h0500_0000,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              CE,
  input  logic [31:0]       A,
  input  logic [31:0]       D_I,
  output logic [31:0]       D_O,
  output logic              DOE,
  input  logic [3:0]        BEn,
  input  logic              MRQn,
  input  logic              RW,
  input  logic              BCYSTn,
  output logic              READYn,
  output logic              SZRQn,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [31:0]       MEM_WD,
  output logic [3:0]        MEM_BE,
  output logic              MEM_WE,
  output logic              MEM_RE,
  input  logic [31:0]       MEM_RD
);

  // Lowest address bit that belongs to the window tag.
  localparam int unsigned TAG_LSB = ADDR_W + 2;
  // Wait-state count as loaded into the 4-bit counter (0..15).
  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FETCH = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  // Registered state and latched request fields.
  state_t            state_q,   state_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic              rw_q,      rw_d;
  logic              split_q,   split_d;
  logic [ADDR_W-1:0] mem_a_q,   mem_a_d;
  logic [3:0]        mem_be_q,  mem_be_d;
  logic [31:0]       d_o_q,     d_o_d;

  // Registered bus-handshake outputs.
  logic              ready_n_q, ready_n_d;
  logic              doe_q,     doe_d;
  logic              szrq_n_q,  szrq_n_d;

  // Request decode.
  logic              tag_match_s;
  logic              hit_s;
  logic              split_s;
  logic [3:0]        be_s;
  logic              strobe_s;
  logic              unused_a_s;

  // The byte offset inside a word is carried by BEn, not by A[1:0].
  assign unused_a_s = ^A[1:0];

  // A cycle is ours when a start strobe and memory request hit our window.
  assign tag_match_s = (A[31:TAG_LSB] == BASE[31:TAG_LSB]);
  assign hit_s       = ~BCYSTn & ~MRQn & tag_match_s;

`ifdef V810_BUS_TARGET_SZRQ_EN
  // A 16-bit port can only take one halfword per cycle: when both halves
  // are enabled, serve the lower half now and request a sizing retry.
  assign split_s = ~(&BEn[3:2]) & ~(&BEn[1:0]);
  assign be_s    = split_s ? {2'b00, ~BEn[1:0]} : ~BEn;
`else
  // Full 32-bit port: byte enables pass straight through, never split.
  assign split_s = 1'b0;
  assign be_s    = ~BEn;
`endif

  // The memory strobe fires in the last wait cycle. It is a pure function
  // of registered state, so it naturally holds while CE is low.
  assign strobe_s = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign MEM_RE   = strobe_s & rw_q;
  assign MEM_WE   = strobe_s & ~rw_q;
  assign MEM_WD   = MEM_WE ? D_I : 32'h0000_0000;

  assign MEM_A    = mem_a_q;
  assign MEM_BE   = mem_be_q;
  assign D_O      = d_o_q;
  assign DOE      = doe_q;
  assign READYn   = ready_n_q;
  assign SZRQn    = szrq_n_q;

  // Next state, request latches, read-data capture and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    split_d  = split_q;
    mem_a_d  = mem_a_q;
    mem_be_d = mem_be_q;
    d_o_d    = d_o_q;
    if (CE) begin
      case (state_q)
        // A new access may start from idle or back-to-back from the
        // acknowledge cycle of the previous one.
        S_IDLE, S_ACK: begin
          if (hit_s) begin
            state_d  = S_WAIT;
            cnt_d    = WS_INIT;
            rw_d     = RW;
            split_d  = split_s;
            mem_a_d  = A[TAG_LSB-1:2];
            mem_be_d = be_s;
          end else begin
            state_d  = S_IDLE;
          end
        end
        // Start strobes seen here are protocol violations and are ignored.
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = rw_q ? S_FETCH : S_ACK;
          end else begin
            cnt_d   = cnt_q - 4'd1;
          end
        end
        // Memory data is valid in the cycle after the read strobe.
        S_FETCH: begin
          d_o_d   = MEM_RD;
          state_d = S_ACK;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Handshake outputs are registered copies of "next cycle is ACK", so
    // they line up exactly with the ACK state and never glitch.
    ready_n_d = ~(state_d == S_ACK);
    doe_d     = (state_d == S_ACK) & rw_d;
    szrq_n_d  = ~((state_d == S_ACK) & split_d);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rw_q      <= 1'b0;
      split_q   <= 1'b0;
      mem_a_q   <= '0;
      mem_be_q  <= 4'b0000;
      d_o_q     <= 32'h0000_0000;
      ready_n_q <= 1'b1;
      doe_q     <= 1'b0;
      szrq_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      split_q   <= split_d;
      mem_a_q   <= mem_a_d;
      mem_be_q  <= mem_be_d;
      d_o_q     <= d_o_d;
      ready_n_q <= ready_n_d;
      doe_q     <= doe_d;
      szrq_n_q  <= szrq_n_d;
    end
  end

endmodule

// File: tb/tb_v810_bus_target.sv
// Scoreboard bench for v810_bus_target: the stimulus process predicts each
// response from bus-protocol rules (latency in CE cycles, byte-lane merge,
// window decode, busy/accept rule) and queues it; a monitor pops and compares
// whenever the target strobes memory or acknowledges a cycle.
module tb_v810_bus_target;

  localparam logic [31:0] BASE   = 32'h0500_0000;
  localparam int          ADDR_W = 14;
  localparam int          WS     = 3;
  localparam int          DEPTH  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RES = 1'b1;
  logic              CE  = 1'b1;
  logic [31:0]       A   = 32'h0;
  logic [31:0]       D_I = 32'h0;
  logic [31:0]       D_O;
  logic              DOE;
  logic [3:0]        BEn = 4'hF;
  logic              MRQn = 1'b1;
  logic              RW = 1'b1;
  logic              BCYSTn = 1'b1;
  logic              READYn;
  logic              SZRQn;
  logic [ADDR_W-1:0] MEM_A;
  logic [31:0]       MEM_WD;
  logic [3:0]        MEM_BE;
  logic              MEM_WE;
  logic              MEM_RE;
  logic [31:0]       MEM_RD;

  v810_bus_target #(.BASE(BASE), .ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .D_I(D_I), .D_O(D_O), .DOE(DOE),
    .BEn(BEn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn),
    .SZRQn(SZRQn), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_BE(MEM_BE),
    .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_cyc   = 0;   // number of CE edges so far = index of current CE cycle

  typedef struct { int cyc; logic rd; logic [31:0] data; logic szrq_n; } ack_t;
  typedef struct { int cyc; logic wr; logic [ADDR_W-1:0] addr; logic [3:0] be; logic [31:0] data; } stb_t;
  ack_t ack_q[$];
  stb_t stb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t, ce_cyc=%0d)", nm, act, exp, $time, ce_cyc);
    end
  endtask

  // Initial memory contents; word 4 holds the classic marker value.
  function automatic logic [31:0] init_word(input int unsigned w);
    if (w == 4) return 32'hDEAD_BEEF;
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] nw);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- memory device attached to the target ----------------
  logic [31:0] env_mem [DEPTH];
  bit          env_vld [DEPTH];
  logic [31:0] mem_rd_r = 32'h0;
  assign MEM_RD = mem_rd_r;

  always @(posedge CLK) begin
    if (CE) begin
      if (MEM_WE) begin
        env_mem[MEM_A] <= merge(env_vld[MEM_A] ? env_mem[MEM_A] : init_word(32'(MEM_A)), MEM_BE, MEM_WD);
        env_vld[MEM_A] <= 1'b1;
      end
      if (MEM_RE) mem_rd_r <= env_vld[MEM_A] ? env_mem[MEM_A] : init_word(32'(MEM_A));
    end
  end

  always @(posedge CLK) if (CE) ce_cyc <= ce_cyc + 1;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  int          last_ack = 0;   // CE cycle of the last predicted ACK
  logic        ce_toggle = 1'b0;

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge CLK) begin : mon
    ack_t ea;
    stb_t es;
    if (!RES && CE) begin
      if (!READYn) begin
        if (ack_q.size() == 0) begin
          chk("ack_expected", 32'(READYn), 32'd1);
        end else begin
          ea = ack_q.pop_front();
          chk("ack_cycle", 32'(ce_cyc), 32'(ea.cyc));
          chk("ack_doe", 32'(DOE), 32'(ea.rd));
          if (ea.rd) chk("ack_d_o", D_O, ea.data);
          chk("ack_szrq_n", 32'(SZRQn), 32'(ea.szrq_n));
        end
      end else begin
        chk("doe_outside_ack", 32'(DOE), 32'd0);
        chk("szrq_outside_ack", 32'(SZRQn), 32'd1);
      end
      if (MEM_RE || MEM_WE) begin
        if (stb_q.size() == 0) begin
          chk("strobe_expected", {30'd0, MEM_RE, MEM_WE}, 32'd0);
        end else begin
          es = stb_q.pop_front();
          chk("strobe_cycle", 32'(ce_cyc), 32'(es.cyc));
          chk("strobe_kind", {30'd0, MEM_RE, MEM_WE}, {30'd0, ~es.wr, es.wr});
          chk("strobe_addr", 32'(MEM_A), 32'(es.addr));
          if (es.wr) begin
            chk("strobe_be", 32'(MEM_BE), 32'(es.be));
            chk("strobe_wd", MEM_WD, es.data);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
    CE     = ce_toggle ? ~CE : 1'b1;
    BCYSTn = 1'b1;
    MRQn   = 1'b1;
  endtask

  task automatic next_ce();
    do step(); while (!CE);
  endtask

  task automatic idle(input int n);
    repeat (n) next_ce();
  endtask

  // Drive one bus cycle start in the first CE cycle at or after at_cyc and
  // predict the target's response.
  task automatic issue(input logic rd, input logic [31:0] addr, input logic [3:0] ben,
                       input logic [31:0] data, input logic mrqn, input int at_cyc);
    int                cyc0;
    logic              hit;
    logic [ADDR_W-1:0] word;
    logic [3:0]        be;
    logic              split;
    ack_t              a;
    stb_t              s;
    do next_ce(); while (ce_cyc < at_cyc);
    cyc0   = ce_cyc;
    BCYSTn = 1'b0;
    MRQn   = mrqn;
    A      = addr;
    RW     = rd;
    BEn    = ben;
    hit    = !mrqn && ((addr >> (ADDR_W + 2)) == (BASE >> (ADDR_W + 2)));
    if (hit && cyc0 >= last_ack) begin
      D_I   = data;
      word  = ADDR_W'(addr >> 2);
      be    = ~ben;
      split = 1'b0;
`ifdef V810_BUS_TARGET_SZRQ_EN
      if (ben[3:2] != 2'b11 && ben[1:0] != 2'b11) begin
        split = 1'b1;
        be    = be & 4'b0011;
      end
`endif
      s.cyc = cyc0 + 1 + WS; s.wr = !rd; s.addr = word; s.be = be; s.data = data;
      stb_q.push_back(s);
      a.rd = rd; a.szrq_n = !split;
      if (rd) begin
        a.cyc  = cyc0 + 3 + WS;
        a.data = ref_rd(int'(word));
      end else begin
        a.cyc  = cyc0 + 2 + WS;
        a.data = 32'h0;
        ref_mem[int'(word)] = merge(ref_rd(int'(word)), be, data);
      end
      ack_q.push_back(a);
      last_ack = a.cyc;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_readyn"}, 32'(READYn), 32'd1);
    chk({tag, "_szrqn"},  32'(SZRQn),  32'd1);
    chk({tag, "_doe"},    32'(DOE),    32'd0);
    chk({tag, "_d_o"},    D_O,         32'd0);
    chk({tag, "_mem_re"}, 32'(MEM_RE), 32'd0);
    chk({tag, "_mem_we"}, 32'(MEM_WE), 32'd0);
    chk({tag, "_mem_a"},  32'(MEM_A),  32'd0);
    chk({tag, "_mem_be"}, 32'(MEM_BE), 32'd0);
    chk({tag, "_mem_wd"}, MEM_WD,      32'd0);
  endtask

  initial begin : stim
    logic [31:0] old6;
    logic [31:0] addr;
    int          sel;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("por");
    @(posedge CLK);
    #1 RES = 1'b0;

    // Directed: read word 4, write with partial lanes, read back.
    issue(1'b1, BASE + 32'h10, 4'h0, 32'h0, 1'b0, 0);
    idle(8);
    issue(1'b0, BASE + 32'h8, 4'b1100, 32'h1234_5678, 1'b0, 0);
    idle(8);
    issue(1'b1, BASE + 32'h8, 4'h0, 32'h0, 1'b0, 0);
    idle(8);

    // Miss just above the window: nothing may happen for 10 cycles.
    issue(1'b0, BASE + (32'h1 << (ADDR_W + 2)), 4'h0, 32'hFFFF_FFFF, 1'b0, 0);
    repeat (10) begin
      next_ce();
      @(negedge CLK);
      chk("miss_readyn", 32'(READYn), 32'd1);
      chk("miss_doe", 32'(DOE), 32'd0);
      chk("miss_strobes", {30'd0, MEM_RE, MEM_WE}, 32'd0);
    end

    // All lanes disabled, then a full write followed by its upper half.
    issue(1'b0, BASE + 32'h20, 4'hF, 32'hCAFE_F00D, 1'b0, 0);
    idle(6);
    issue(1'b1, BASE + 32'h20, 4'h0, 32'h0, 1'b0, 0);
    idle(8);
    issue(1'b0, BASE + 32'h30, 4'h0, 32'hA1B2_C3D4, 1'b0, 0);
    idle(6);
    issue(1'b0, BASE + 32'h30, 4'b0011, 32'hA1B2_C3D4, 1'b0, 0);
    idle(6);
    issue(1'b1, BASE + 32'h30, 4'h0, 32'h0, 1'b0, 0);
    idle(8);

    // Back-to-back from ACK, at full rate and with CE at half rate.
    for (int t = 0; t < 2; t++) begin
      ce_toggle = (t == 1);
      issue(1'b0, BASE + 32'h40, 4'h0, 32'h1111_2222 + t, 1'b0, 0);
      issue(1'b1, BASE + 32'h40, 4'h0, 32'h0, 1'b0, last_ack);
      issue(1'b0, BASE + 32'h44, 4'b0101, 32'h3333_4444, 1'b0, last_ack);
      idle(10);
    end
    ce_toggle = 1'b0;

    // Reset in the middle of a write's wait states: the write must vanish.
    old6 = ref_rd(6);
    issue(1'b0, BASE + 32'h18, 4'h0, 32'h0BAD_0BAD, 1'b0, 0);
    idle(1);
    step();
    RES = 1'b1;
    ack_q.delete();
    stb_q.delete();
    last_ack = 0;
    ref_mem[6] = old6;
    @(negedge CLK);
    check_reset_vals("mid_reset");
    step();
    step();
    RES = 1'b0;
    idle(10);
    issue(1'b1, BASE + 32'h18, 4'h0, 32'h0, 1'b0, 0);
    idle(8);

    // Randomized traffic: hits, misses, no-request cycles, early restarts.
    for (int i = 0; i < 300; i++) begin
      ce_toggle = ($urandom_range(0, 3) == 0);
      sel  = int'($urandom_range(0, 9));
      addr = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      if (sel == 0) addr = addr ^ (32'h1 << $urandom_range(ADDR_W + 2, 31));
      issue(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom(),
            (sel == 1), ($urandom_range(0, 2) == 0) ? last_ack : 0);
      idle(int'($urandom_range(0, 7)));
    end
    ce_toggle = 1'b0;

    idle(40);
    chk("ack_drain", 32'(ack_q.size()), 32'd0);
    chk("strobe_drain", 32'(stb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
